// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, line type and FSM encoding for the data cache
package dcache_pkg;

   localparam int DC_ADDR_W = 12;
   localparam int DC_LINES  = 8;
   localparam int DC_WPL    = 4;
   localparam int WORD_W    = 32;
   localparam int LINE_W    = DC_WPL * WORD_W;
   localparam int OFF_W     = 4;

   typedef logic [LINE_W-1:0] line_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COMPARE,
      ST_WRITEBACK,
      ST_REFILL,
      ST_RELEASE
   } state_e;

   function automatic logic [WORD_W-1:0] line_word(input line_t line, input logic [1:0] sel);
      logic [WORD_W-1:0] w;
      case (sel)
         2'd0:    w = line[31:0];
         2'd1:    w = line[63:32];
         2'd2:    w = line[95:64];
         default: w = line[127:96];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/dcache_store.sv
// rtl/dcache_store.sv - tag/valid/dirty/data arrays with a byte-merging word write port
module dcache_store
   import dcache_pkg::*;
#(
   parameter int LINES = DC_LINES,
   parameter int TAG_W = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [$clog2(LINES)-1:0] idx_i,
   output logic [TAG_W-1:0]         rd_tag_o,
   output logic                     rd_valid_o,
   output logic                     rd_dirty_o,
   output line_t                    rd_line_o,
   input  logic                     wr_en_i,
   input  logic [1:0]               word_i,
   input  logic [3:0]               be_i,
   input  logic [WORD_W-1:0]        din_i,
   input  logic                     refill_en_i,
   input  logic [TAG_W-1:0]         refill_tag_i,
   input  line_t                    refill_line_i
);

   logic [TAG_W-1:0] tag_q   [LINES];
   line_t            data_q  [LINES];
   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   line_t            merged;

   assign rd_tag_o   = tag_q[idx_i];
   assign rd_valid_o = valid_q[idx_i];
   assign rd_dirty_o = dirty_q[idx_i];
   assign rd_line_o  = data_q[idx_i];

   always_comb begin
      merged = data_q[idx_i];
      for (int w = 0; w < DC_WPL; w++) begin
         for (int b = 0; b < 4; b++) begin
            if ((2'(w) == word_i) && be_i[b]) begin
               merged[WORD_W*w + 8*b +: 8] = din_i[8*b +: 8];
            end
         end
      end
   end

   // Only the status bits need reset; tag/data are don't-care while invalid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (refill_en_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (wr_en_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (refill_en_i) begin
         data_q[idx_i] <= refill_line_i;
         tag_q[idx_i]  <= refill_tag_i;
      end else if (wr_en_i) begin
         data_q[idx_i] <= merged;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_W = DC_ADDR_W,
   parameter int LINES  = DC_LINES
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [3:0]        BE,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [WORD_W-1:0] D_IN,
   output logic [WORD_W-1:0] D_OUT,
   output logic              Cache_RDY,
   output logic              Cache_VALID,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output line_t             MEM_WDATA,
   input  line_t             MEM_RDATA,
   input  logic              MEM_ACK
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

   state_e              state_q, state_d;
   logic [ADDR_W-1:2]   addr_q, addr_d;
   logic [WORD_W-1:0]   din_q, din_d;
   logic [3:0]          be_q, be_d;
   logic                we_q, we_d;
   logic [WORD_W-1:0]   d_out_q, d_out_d;
   logic                rdy_q, rdy_d;
   logic                cvalid_q, cvalid_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   line_t               mem_wdata_q, mem_wdata_d;

   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic [1:0]          req_word;
   logic [TAG_W-1:0]    rd_tag;
   logic                rd_valid;
   logic                rd_dirty;
   line_t               rd_line;
   logic                hit;
   logic                request;
   logic                ack_ok;
   logic                st_wr_en;
   logic                st_refill_en;
   logic                unused_addr_lsb;

   assign unused_addr_lsb = ^ADDR[1:0];

   assign req_word = addr_q[3:2];
   assign req_idx  = addr_q[OFF_W +: IDX_W];
   assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
   assign request  = MemRead | MemWrite;
   assign hit      = rd_valid && (rd_tag == req_tag);
   // An ACK only counts while a request is outstanding.
   assign ack_ok   = MEM_ACK && mem_req_q;

   dcache_store #(
      .LINES (LINES),
      .TAG_W (TAG_W)
   ) u_store (
      .clk_i         (CLK),
      .rst_ni        (RSTn),
      .idx_i         (req_idx),
      .rd_tag_o      (rd_tag),
      .rd_valid_o    (rd_valid),
      .rd_dirty_o    (rd_dirty),
      .rd_line_o     (rd_line),
      .wr_en_i       (st_wr_en),
      .word_i        (req_word),
      .be_i          (be_q),
      .din_i         (din_q),
      .refill_en_i   (st_refill_en),
      .refill_tag_i  (req_tag),
      .refill_line_i (MEM_RDATA)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      din_d        = din_q;
      be_d         = be_q;
      we_d         = we_q;
      d_out_d      = d_out_q;
      rdy_d        = 1'b0;
      cvalid_d     = 1'b0;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      st_wr_en     = 1'b0;
      st_refill_en = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (request) begin
               addr_d  = ADDR[ADDR_W-1:2];
               din_d   = D_IN;
               be_d    = BE;
               we_d    = MemWrite;
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (hit) begin
               rdy_d = 1'b1;
               if (we_q) begin
                  st_wr_en = 1'b1;
               end else begin
                  cvalid_d = 1'b1;
                  d_out_d  = line_word(rd_line, req_word);
               end
               state_d = ST_RELEASE;
            end else if (rd_valid && rd_dirty) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {rd_tag, req_idx, {OFF_W{1'b0}}};
               mem_wdata_d = rd_line;
               state_d     = ST_WRITEBACK;
            end else begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               state_d    = ST_REFILL;
            end
         end
         ST_WRITEBACK: begin
            if (ack_ok) begin
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               state_d    = ST_REFILL;
            end
         end
         ST_REFILL: begin
            // After a write-back the request stays low one cycle, then re-asserts here.
            if (ack_ok) begin
               st_refill_en = 1'b1;
               mem_req_d    = 1'b0;
               state_d      = ST_COMPARE;
            end else begin
               mem_req_d = 1'b1;
               mem_we_d  = 1'b0;
            end
         end
         ST_RELEASE: begin
            if (!request) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         be_q        <= '0;
         we_q        <= 1'b0;
         d_out_q     <= '0;
         rdy_q       <= 1'b0;
         cvalid_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         be_q        <= be_d;
         we_q        <= we_d;
         d_out_q     <= d_out_d;
         rdy_q       <= rdy_d;
         cvalid_q    <= cvalid_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign D_OUT       = d_out_q;
   assign Cache_RDY   = rdy_q;
   assign Cache_VALID = cvalid_q;
   assign MEM_REQ     = mem_req_q;
   assign MEM_WE      = mem_we_q;
   assign MEM_ADDR    = mem_addr_q;
   assign MEM_WDATA   = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized bench for dcache_ctrl against a flat-memory reference model
module tb_dcache_ctrl;

   logic         CLK = 1'b0;
   logic         RSTn = 1'b0;
   logic         MemRead = 1'b0;
   logic         MemWrite = 1'b0;
   logic [3:0]   BE = 4'h0;
   logic [11:0]  ADDR = 12'h0;
   logic [31:0]  D_IN = 32'h0;
   logic [31:0]  D_OUT;
   logic         Cache_RDY;
   logic         Cache_VALID;
   logic         MEM_REQ;
   logic         MEM_WE;
   logic [11:0]  MEM_ADDR;
   logic [127:0] MEM_WDATA;
   logic [127:0] MEM_RDATA = '0;
   logic         MEM_ACK = 1'b0;

   dcache_ctrl dut (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .BE          (BE),
      .ADDR        (ADDR),
      .D_IN        (D_IN),
      .D_OUT       (D_OUT),
      .Cache_RDY   (Cache_RDY),
      .Cache_VALID (Cache_VALID),
      .MEM_REQ     (MEM_REQ),
      .MEM_WE      (MEM_WE),
      .MEM_ADDR    (MEM_ADDR),
      .MEM_WDATA   (MEM_WDATA),
      .MEM_RDATA   (MEM_RDATA),
      .MEM_ACK     (MEM_ACK)
   );

   always #5 CLK = ~CLK;

   int           n_chk = 0;
   int           n_pass = 0;
   logic [127:0] mem  [256];
   logic [127:0] gold [256];
   bit           m_valid [8];
   bit           m_dirty [8];
   int           m_tag   [8];
   logic [12:0]  op_log [$];
   logic [12:0]  op_exp [$];
   bit           resp_en = 1'b1;
   bit           stray_req = 1'b0;
   bit           armed = 1'b0;
   int           dly = 0;
   logic [31:0]  last_load = 32'h0;
   bit           found;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Main memory behind the cache: random ACK latency, write-backs compared with the reference.
   always @(negedge CLK) begin
      int la;
      MEM_ACK = 1'b0;
      if (stray_req) begin
         MEM_ACK   = 1'b1;
         MEM_RDATA = {$urandom, $urandom, $urandom, $urandom};
         stray_req = 1'b0;
      end else if (resp_en && MEM_REQ) begin
         if (!armed) begin
            armed = 1'b1;
            dly   = $urandom_range(0, 3);
         end
         if (dly == 0) begin
            armed = 1'b0;
            la = int'(MEM_ADDR[11:4]);
            chk("mem_addr_align", MEM_ADDR[3:0], 4'h0);
            if (MEM_WE) begin
               chk("wb_data", MEM_WDATA, gold[la]);
               mem[la] = MEM_WDATA;
            end else begin
               MEM_RDATA = mem[la];
            end
            op_log.push_back({MEM_WE, MEM_ADDR});
            MEM_ACK = 1'b1;
         end else begin
            dly--;
         end
      end else begin
         armed = 1'b0;
      end
   end

   task automatic reset_checks();
      chk("rst_d_out", D_OUT, 32'h0);
      chk("rst_rdy", Cache_RDY, 1'b0);
      chk("rst_valid", Cache_VALID, 1'b0);
      chk("rst_mem_req", MEM_REQ, 1'b0);
      chk("rst_mem_we", MEM_WE, 1'b0);
      chk("rst_mem_addr", MEM_ADDR, 12'h0);
      chk("rst_mem_wdata", MEM_WDATA, 128'h0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = 0;
      end
      for (int i = 0; i < 256; i++) gold[i] = mem[i];
      last_load = 32'h0;
   endtask

   task automatic access(input bit we, input logic [11:0] a, input logic [3:0] be,
                         input logic [31:0] din, input int hold);
      int idx, tg, la, w, cnt;
      bit hit, got;
      idx = int'(a[6:4]);
      tg  = int'(a[11:7]);
      la  = int'(a[11:4]);
      w   = int'(a[3:2]);
      op_exp.delete();
      op_log.delete();
      hit = m_valid[idx] && (m_tag[idx] == tg);
      if (!hit) begin
         if (m_valid[idx] && m_dirty[idx])
            op_exp.push_back({1'b1, 5'(m_tag[idx]), 3'(idx), 4'h0});
         op_exp.push_back({1'b0, a[11:4], 4'h0});
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
      end
      if (we) begin
         m_dirty[idx] = 1'b1;
         for (int b = 0; b < 4; b++)
            if (be[b]) gold[la][32*w + 8*b +: 8] = din[8*b +: 8];
      end
      @(negedge CLK);
      MemRead  = 1'b1;
      MemWrite = we;
      ADDR     = a;
      BE       = be;
      D_IN     = din;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 400) begin
         @(negedge CLK);
         cnt++;
         if (cnt == 1) begin
            MemWrite = 1'($urandom);
            ADDR     = 12'($urandom);
            BE       = 4'($urandom);
            D_IN     = $urandom;
         end
         got = Cache_RDY;
      end
      chk("rdy_seen", got, 1'b1);
      if (hit) chk("hit_latency", cnt, 2);
      chk("cache_valid", Cache_VALID, !we);
      if (!we) last_load = gold[la][32*w +: 32];
      chk("d_out", D_OUT, last_load);
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         chk("rdy_single_pulse", Cache_RDY, 1'b0);
      end
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      @(negedge CLK);
      chk("rdy_after_release", Cache_RDY, 1'b0);
      chk("mem_ops_count", op_log.size(), op_exp.size());
      for (int i = 0; i < op_exp.size() && i < op_log.size(); i++)
         chk("mem_op", op_log[i], op_exp[i]);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      mem[4][31:0]  = 32'hDEADBEEF;
      mem[4][63:32] = 32'hDEADBEEF;
      model_reset();

      repeat (3) @(negedge CLK);
      reset_checks();
      RSTn = 1'b1;

      // Cold load, held-request hit, partial store, dirty eviction
      access(1'b0, 12'h040, 4'h0, 32'h0, 0);
      chk("cold_load_value", D_OUT, 32'hDEADBEEF);
      access(1'b0, 12'h044, 4'h0, 32'h0, 3);
      access(1'b1, 12'h048, 4'b0011, 32'h11223344, 1);
      access(1'b0, 12'h048, 4'h0, 32'h0, 0);
      chk("merged_low_half", D_OUT[15:0], 16'h3344);
      access(1'b0, 12'h840, 4'h0, 32'h0, 0);
      access(1'b1, 12'h0C4, 4'b0000, 32'hFFFFFFFF, 0);

      // Reset in the middle of a refill
      resp_en = 1'b0;
      @(negedge CLK);
      MemRead = 1'b1;
      ADDR    = 12'h100;
      found   = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge CLK);
         found = MEM_REQ;
      end
      chk("refill_req_seen", found, 1'b1);
      chk("refill_we", MEM_WE, 1'b0);
      chk("refill_addr", MEM_ADDR, 12'h100);
      RSTn    = 1'b0;
      MemRead = 1'b0;
      #1;
      chk("req_drop_on_reset", MEM_REQ, 1'b0);
      @(negedge CLK);
      reset_checks();
      RSTn    = 1'b1;
      resp_en = 1'b1;
      model_reset();
      access(1'b0, 12'h040, 4'h0, 32'h0, 0);

      // Stray ACK while idle
      @(negedge CLK);
      stray_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("stray_rdy", Cache_RDY, 1'b0);
         chk("stray_req", MEM_REQ, 1'b0);
      end
      access(1'b0, 12'h040, 4'h0, 32'h0, 0);

      // Random traffic over a few colliding tags
      for (int n = 0; n < 300; n++) begin
         logic [4:0]  t;
         logic [11:0] a;
         case ($urandom_range(0, 3))
            0:       t = 5'd0;
            1:       t = 5'd1;
            2:       t = 5'd2;
            default: t = 5'd16;
         endcase
         a = {t, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         access(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
